vram_uart_dump: RTL and testbench



---
 rtl/vram_pkg.sv | 18 +
 rtl/uart_tx_byte.sv | 53 +++++
 rtl/vram_uart_dump.sv | 140 ++++++++++++++
 tb/tb_vram_uart_dump.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vram_pkg.sv
// rtl/vram_pkg.sv - shared text-VRAM geometry, ASCII constants and address packing
package vram_pkg;

    localparam int VRAM_AW = 11;
    localparam int X_W     = 6;
    localparam int Y_W     = 5;

    localparam logic [7:0] ASCII_CR  = 8'h0D;
    localparam logic [7:0] ASCII_LF  = 8'h0A;
    localparam logic [7:0] ASCII_DOT = 8'h2E;

    // Row-major cell address; rows are 64 cells apart regardless of visible width.
    function automatic logic [VRAM_AW-1:0] vram_addr_pack(input logic [Y_W-1:0] y,
                                                          input logic [X_W-1:0] x);
        return {y, x};
    endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// rtl/uart_tx_byte.sv - 8N1 UART byte serializer with valid/ready handshake
module uart_tx_byte #(
    parameter int CLKS_PER_BIT = 104
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_valid,
    input  logic [7:0] i_data,
    output logic       o_ready,
    output logic       o_tx
);

    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0] BAUD_RELOAD = BW'(CLKS_PER_BIT - 1);

    logic          busy;
    logic [3:0]    bit_cnt;
    logic [BW-1:0] baud_cnt;
    logic [8:0]    shreg;
    logic          last_cycle;

    // Ready in the final stop-bit cycle lets the next start bit follow with no gap.
    assign last_cycle = busy && (bit_cnt == 4'd9) && (baud_cnt == '0);
    assign o_ready    = !busy || last_cycle;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            busy     <= 1'b0;
            bit_cnt  <= 4'd0;
            baud_cnt <= '0;
            shreg    <= '1;
            o_tx     <= 1'b1;
        end else if (i_valid && o_ready) begin
            busy     <= 1'b1;
            bit_cnt  <= 4'd0;
            baud_cnt <= BAUD_RELOAD;
            shreg    <= {1'b1, i_data};
            o_tx     <= 1'b0;
        end else if (busy) begin
            if (baud_cnt != '0) begin
                baud_cnt <= baud_cnt - BW'(1);
            end else if (bit_cnt == 4'd9) begin
                busy <= 1'b0;
            end else begin
                o_tx     <= shreg[0];
                shreg    <= {1'b1, shreg[8:1]};
                bit_cnt  <= bit_cnt + 4'd1;
                baud_cnt <= BAUD_RELOAD;
            end
        end
    end

endmodule

// File: rtl/vram_uart_dump.sv
// rtl/vram_uart_dump.sv - streams the visible text grid over UART with CR LF per row; DUMP_SANITIZE_EN maps non-printables to '.'
module vram_uart_dump
    import vram_pkg::*;
#(
    parameter int COLS         = 60,
    parameter int ROWS         = 17,
    parameter int CLKS_PER_BIT = 104,
    parameter int VRAM_LAT     = 1
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_start,
    output logic        o_running,
    output logic [10:0] o_vram_addr,
    output logic        o_vram_ce,
    output logic        o_vram_w,
    input  logic [7:0]  i_vram_dout,
    output logic        o_tx
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_WAIT   = 3'd2;
    localparam logic [2:0] S_HOLD   = 3'd3;
    localparam logic [2:0] S_EOL_CR = 3'd4;
    localparam logic [2:0] S_EOL_LF = 3'd5;
    localparam logic [2:0] S_DRAIN  = 3'd6;

    localparam logic [X_W-1:0] X_LAST   = X_W'(COLS - 1);
    localparam logic [Y_W-1:0] Y_LAST   = Y_W'(ROWS - 1);
    localparam logic [1:0]     LAT_LAST = 2'(VRAM_LAT - 1);

    logic [2:0]     state;
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
    logic [1:0]     lat_cnt;
    logic [7:0]     byte_buf;
    logic           running;
    logic           tx_valid;
    logic [7:0]     tx_data;
    logic           tx_ready;

    function automatic logic [7:0] scrub(input logic [7:0] b);
`ifdef DUMP_SANITIZE_EN
        return (b < 8'h20 || b >= 8'h7F) ? ASCII_DOT : b;
`else
        return b;
`endif
    endfunction

    always_comb begin
        tx_valid = 1'b0;
        tx_data  = byte_buf;
        case (state)
            S_HOLD:   tx_valid = 1'b1;
            S_EOL_CR: begin
                tx_valid = 1'b1;
                tx_data  = ASCII_CR;
            end
            S_EOL_LF: begin
                tx_valid = 1'b1;
                tx_data  = ASCII_LF;
            end
            default: ;
        endcase
    end

    assign o_vram_ce   = (state == S_FETCH);
    assign o_vram_addr = vram_addr_pack(y, x);
    assign o_vram_w    = 1'b0;
    assign o_running   = running;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state    <= S_IDLE;
            x        <= '0;
            y        <= '0;
            lat_cnt  <= 2'd0;
            byte_buf <= 8'h00;
            running  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (i_start) begin
                    x       <= '0;
                    y       <= '0;
                    running <= 1'b1;
                    state   <= S_FETCH;
                end
                S_FETCH: begin
                    lat_cnt <= 2'd0;
                    state   <= S_WAIT;
                end
                S_WAIT: begin
                    if (lat_cnt == LAT_LAST) begin
                        byte_buf <= scrub(i_vram_dout);
                        state    <= S_HOLD;
                    end else begin
                        lat_cnt <= lat_cnt + 2'd1;
                    end
                end
                // Next cell is fetched while the current byte is still on the wire.
                S_HOLD: if (tx_ready) begin
                    if (x == X_LAST) begin
                        state <= S_EOL_CR;
                    end else begin
                        x     <= x + X_W'(1);
                        state <= S_FETCH;
                    end
                end
                S_EOL_CR: if (tx_ready) state <= S_EOL_LF;
                S_EOL_LF: if (tx_ready) begin
                    if (y == Y_LAST) begin
                        state <= S_DRAIN;
                    end else begin
                        x     <= '0;
                        y     <= y + Y_W'(1);
                        state <= S_FETCH;
                    end
                end
                S_DRAIN: if (tx_ready) begin
                    running <= 1'b0;
                    state   <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_tx (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_valid(tx_valid),
        .i_data (tx_data),
        .o_ready(tx_ready),
        .o_tx   (o_tx)
    );

endmodule

// File: tb/tb_vram_uart_dump.sv
// tb/tb_vram_uart_dump.sv - scoreboard bench for vram_uart_dump at VRAM latency 1 and 3
module tb_vram_uart_dump;

    localparam int CPB = 4;
    localparam int NC  = 4;
    localparam int NR  = 2;

    logic clk = 1'b0;
    logic rst;
    logic start;
    int   sel;
    int   cyc = 0;

    logic [1:0]  tx_w, run_w, ce_w, w_w, st_w;
    logic [10:0] addr_w [2];
    logic [7:0]  dout_w [2];
    logic [7:0]  mem [0:2047];

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0]  exp_q [$];
    logic [10:0] addr_q [$];

    logic mon_en = 1'b0;
    int   frames, gaps, first_start, last_end;
    bit   have_prev;
    bit   w_bad;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign st_w[0] = start && (sel == 0);
    assign st_w[1] = start && (sel == 1);

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int LAT = (g == 0) ? 1 : 3;
        logic [7:0] p1, p2, p3;

        vram_uart_dump #(
            .COLS(NC), .ROWS(NR), .CLKS_PER_BIT(CPB), .VRAM_LAT(LAT)
        ) u_dut (
            .i_clk      (clk),
            .i_rst      (rst),
            .i_start    (st_w[g]),
            .o_running  (run_w[g]),
            .o_vram_addr(addr_w[g]),
            .o_vram_ce  (ce_w[g]),
            .o_vram_w   (w_w[g]),
            .i_vram_dout(dout_w[g]),
            .o_tx       (tx_w[g])
        );

        always @(posedge clk) begin
            if (ce_w[g]) p1 <= mem[addr_w[g]];
            p2 <= p1;
            p3 <= p2;
        end
        assign dout_w[g] = (LAT == 1) ? p1 : p3;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] exp_byte(input logic [7:0] b);
`ifdef DUMP_SANITIZE_EN
        return (b < 8'h20 || b >= 8'h7F) ? 8'h2E : b;
`else
        return b;
`endif
    endfunction

    // UART receiver: samples mid-bit, checks framing, inter-frame gap and byte order.
    int         t0;
    logic [7:0] rb;
    logic       sb0, sb9;
    always begin : uart_mon
        @(negedge clk);
        if (mon_en && tx_w[sel] === 1'b0) begin
            t0 = cyc;
            repeat (CPB / 2) @(negedge clk);
            sb0 = tx_w[sel];
            for (int i = 0; i < 8; i++) begin
                repeat (CPB) @(negedge clk);
                rb[i] = tx_w[sel];
            end
            repeat (CPB) @(negedge clk);
            sb9 = tx_w[sel];
            if (mon_en) begin
                if (frames == 0) first_start = t0;
                if (have_prev) begin
                    chk("gap", t0 - last_end, 0);
                    gaps++;
                end
                chk("start_bit", {31'd0, sb0}, 0);
                chk("stop_bit", {31'd0, sb9}, 1);
                if (exp_q.size() == 0) chk("extra_byte", {24'd0, rb}, 32'hFFFF);
                else chk("byte", {24'd0, rb}, {24'd0, exp_q.pop_front()});
                last_end  = t0 + 10 * CPB;
                have_prev = 1;
                frames++;
            end
        end
    end

    bit prev_ce = 0;
    always begin : addr_mon
        @(negedge clk);
        if (mon_en) begin
            if (ce_w[sel]) begin
                if (prev_ce) chk("ce_width", 2, 1);
                if (addr_q.size() == 0) chk("extra_read", {21'd0, addr_w[sel]}, 32'hFFFF);
                else chk("addr", {21'd0, addr_w[sel]}, {21'd0, addr_q.pop_front()});
            end
            if (w_w[sel] !== 1'b0) w_bad = 1;
            prev_ce = ce_w[sel];
        end else begin
            prev_ce = 0;
        end
    end

    task automatic push_exp();
        logic [10:0] a;
        for (int y = 0; y < NR; y++) begin
            for (int x = 0; x < NC; x++) begin
                a = {5'(y), 6'(x)};
                addr_q.push_back(a);
                exp_q.push_back(exp_byte(mem[a]));
            end
            exp_q.push_back(8'h0D);
            exp_q.push_back(8'h0A);
        end
    endtask

    task automatic run_dump(input int busy_at);
        int s, n, fall, lat;
        bit pulsed;
        lat = (sel == 0) ? 1 : 3;
        push_exp();
        frames = 0; gaps = 0; have_prev = 0; w_bad = 0; pulsed = 0;
        @(negedge clk);
        start = 1'b1;
        s = cyc;
        @(negedge clk);
        start = 1'b0;
        chk("run_rise", {31'd0, run_w[sel]}, 1);
        n = 0;
        while (run_w[sel] === 1'b1 && n < 3000) begin
            @(negedge clk);
            n++;
            start = 1'b0;
            if (!pulsed && busy_at > 0 && frames == busy_at) begin
                start  = 1'b1;
                pulsed = 1;
            end
        end
        start = 1'b0;
        fall  = cyc;
        chk("dump_timeout", {31'd0, n < 3000}, 1);
        chk("frames", frames, NR * (NC + 2));
        chk("gaps", gaps, NR * (NC + 2) - 1);
        chk("duration", last_end - first_start, NR * (NC + 2) * 10 * CPB);
        chk("startup", {31'd0, (first_start - s - 1) <= lat + 3}, 1);
        chk("run_fall", {31'd0, fall >= last_end && fall <= last_end + 1}, 1);
        chk("bytes_left", exp_q.size(), 0);
        chk("reads_left", addr_q.size(), 0);
        chk("vram_w", {31'd0, w_bad}, 0);
        exp_q.delete();
        addr_q.delete();
        repeat (20) @(negedge clk);
    endtask

    bit saw_low;
    bit abort_bad;

    initial begin
        for (int i = 0; i < 2048; i++) mem[i] = 8'h00;
        rst = 1'b1;
        start = 1'b0;
        sel = 0;
        repeat (3) begin
            @(negedge clk);
            chk("rst_tx", {31'd0, tx_w[0]}, 1);
            chk("rst_running", {31'd0, run_w[0]}, 0);
            chk("rst_ce", {31'd0, ce_w[0]}, 0);
        end
        chk("rst_addr", {21'd0, addr_w[0]}, 0);
        chk("rst_w", {31'd0, w_w[0]}, 0);
        rst = 1'b0;

        saw_low = 0;
        repeat (1000) begin
            @(negedge clk);
            if (tx_w[0] !== 1'b1 || run_w[0] !== 1'b0) saw_low = 1;
        end
        chk("idle_quiet", {31'd0, saw_low}, 0);

        mem[11'h000] = "A"; mem[11'h001] = "B"; mem[11'h002] = "C"; mem[11'h003] = "D";
        mem[11'h040] = "w"; mem[11'h041] = "x"; mem[11'h042] = "y"; mem[11'h043] = "z";
        mon_en = 1'b1;
        run_dump(0);
        run_dump(5);

        // Reset in the middle of the third frame, with the receiver switched off.
        mon_en = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (93) @(negedge clk);
        chk("abort_pre_run", {31'd0, run_w[0]}, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_tx", {31'd0, tx_w[0]}, 1);
        chk("abort_run", {31'd0, run_w[0]}, 0);
        chk("abort_ce", {31'd0, ce_w[0]}, 0);
        abort_bad = 0;
        repeat (60) begin
            @(negedge clk);
            if (tx_w[0] !== 1'b1 || run_w[0] !== 1'b0) abort_bad = 1;
        end
        chk("abort_quiet", {31'd0, abort_bad}, 0);
        mon_en = 1'b1;
        run_dump(0);

        sel = 1;
        run_dump(0);
        run_dump(3);

        sel = 0;
        mem[11'h000] = 8'h07;
        mem[11'h001] = 8'hFF;
        mem[11'h041] = 8'h7F;
        mem[11'h042] = 8'h1F;
        run_dump(0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
